// File: rtl/prbs_lfsr_gen_if.sv
// -----------------------------------------------------------------------------
// prbs_lfsr_gen_if
//   Bundle of control and handshake signals between the PRBS generator and
//   its consumer.
//
//   Signals:
//     en        generator enable                     (consumer -> generator)
//     load      load seed_in into the LFSR           (consumer -> generator)
//     seed_in   runtime seed, WIDTH bits             (consumer -> generator)
//     out_ready consumer accepts out_data            (consumer -> generator)
//     out_valid out_data valid                       (generator -> consumer)
//     out_data  pseudo-random word, OUT_W bits       (generator -> consumer)
//     lockup    one-cycle all-ones recovery pulse    (generator -> consumer)
//     err_inj   invert bit 0 of the transferred word (consumer -> generator,
//               present only when PRBS_ERR_INJ_EN is defined)
//
//   Modports: master = consumer side, slave = generator side.
// -----------------------------------------------------------------------------
interface prbs_lfsr_gen_if #(
  parameter int WIDTH = 31,
  parameter int OUT_W = 1
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             out_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             lockup;
`ifdef PRBS_ERR_INJ_EN
  logic             err_inj;
`endif

`ifdef PRBS_ERR_INJ_EN
  modport master (
    output en, load, seed_in, out_ready, err_inj,
    input  out_valid, out_data, lockup
  );
  modport slave (
    input  en, load, seed_in, out_ready, err_inj,
    output out_valid, out_data, lockup
  );
`else
  modport master (
    output en, load, seed_in, out_ready,
    input  out_valid, out_data, lockup
  );
  modport slave (
    input  en, load, seed_in, out_ready,
    output out_valid, out_data, lockup
  );
`endif
endinterface

// File: rtl/prbs_lfsr_gen.sv
// -----------------------------------------------------------------------------
// prbs_lfsr_gen
//   Fibonacci XNOR LFSR pseudo-random bit generator with a valid/ready output.
//   One step: S' = {S[WIDTH-2:0], S[WIDTH-1] ~^ S[TAP-1]}.
//   out_data[i] is bit 0 of the state after i steps; a transfer advances the
//   state by OUT_W steps in one clock.
//
//   Ports:
//     clk   clock, everything on the rising edge
//     rst   synchronous active-high reset
//     bus   prbs_lfsr_gen_if.slave: en, load, seed_in, out_ready in;
//           out_valid, out_data, lockup out (err_inj in, optional)
//
//   Optional feature macro: PRBS_ERR_INJ_EN
//     When defined, bus.err_inj = 1 on a transfer cycle inverts out_data[0]
//     of that word only; the state sequence is not affected.
// -----------------------------------------------------------------------------
module prbs_lfsr_gen #(
  parameter int               WIDTH      = 31,
  parameter int               TAP        = 28,
  parameter int               OUT_W      = 1,
  parameter logic [WIDTH-1:0] SEED       = '0,
  parameter bit               CLR_ON_DIS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  prbs_lfsr_gen_if.slave bus
);

  // Parameter sanity: refuse to elaborate illegal configurations.
  if (WIDTH < 3 || WIDTH > 64) begin : g_bad_width
    $error("prbs_lfsr_gen: WIDTH must be 3..64");
  end
  if (TAP < 1 || TAP >= WIDTH) begin : g_bad_tap
    $error("prbs_lfsr_gen: TAP must satisfy 1 <= TAP < WIDTH");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_outw
    $error("prbs_lfsr_gen: OUT_W must be 1..WIDTH");
  end
  if (SEED == {WIDTH{1'b1}}) begin : g_bad_seed
    $error("prbs_lfsr_gen: SEED must not be all-ones (XNOR lock-up state)");
  end

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], s[WIDTH-1] ~^ s[TAP-1]};
  endfunction

  logic [WIDTH-1:0] state_q, state_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] adv_state;
  logic [OUT_W-1:0] data_raw;
  logic             xfer;
  logic             all_ones;

  assign xfer     = valid_q & bus.out_ready;
  // All-ones is the only state an XNOR LFSR can never leave.
  assign all_ones = &state_q;

  // Unrolled multi-step walk: word bits and the post-transfer state together.
  always_comb begin
    logic [WIDTH-1:0] walk;
    walk     = state_q;
    data_raw = '0;
    for (int i = 0; i < OUT_W; i++) begin
      data_raw[i] = walk[0];
      walk        = lfsr_step(walk);
    end
    adv_state = walk;
  end

  // Next-state selection in priority order: lock-up, load, disable, run.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    lockup_d = 1'b0;
    if (all_ones) begin
      state_d  = SEED;
      valid_d  = 1'b0;
      lockup_d = 1'b1;
    end else if (bus.load) begin
      // Takes precedence over en=0, so a seed loaded while disabled survives.
      state_d = bus.seed_in;
      valid_d = 1'b0;
    end else if (!bus.en) begin
      if (CLR_ON_DIS) begin
        state_d = SEED;
      end
      valid_d = 1'b0;
    end else begin
      if (xfer) begin
        state_d = adv_state;
      end
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEED;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.lockup    = lockup_q;

`ifdef PRBS_ERR_INJ_EN
  always_comb begin
    bus.out_data    = data_raw;
    // Corrupt only the delivered copy; the state walk above is untouched.
    bus.out_data[0] = data_raw[0] ^ (bus.err_inj & xfer);
  end
`else
  assign bus.out_data = data_raw;
`endif

endmodule
